// File: rtl/morse_rx_param.sv
// Morse receiver: debounced keys build a dot/dash group that decodes to a 6-bit
// character code (A-Z = 0..25, digits = 26..35, 63 = invalid) kept in a short history.
module morse_rx_param #(
  parameter int DEBOUNCE   = 4,
  parameter int HIST_DEPTH = 4,
  parameter int TICK_W     = 8,
  parameter int DASH_TICKS = 3,
  parameter int GAP_TICKS  = 7
) (
  input  logic                    wiCLK,
  input  logic                    wrst,
  input  logic [3:0]              wKEY,
  input  logic                    wMode,
  input  logic                    wTick,
  input  logic                    wSW,
  output logic [6*HIST_DEPTH-1:0] wHist,
  output logic [5:0]              wLast,
  output logic                    wValid,
  output logic [4:0]              wStack,
  output logic [2:0]              wCount,
  output logic                    wOvf
);

  localparam logic [TICK_W-1:0] DASH_T  = TICK_W'(DASH_TICKS);
  localparam logic [TICK_W-1:0] GAP_END = TICK_W'(GAP_TICKS - 1);

  logic [3:0][DEBOUNCE-1:0]   sh_q;
  logic [3:0]                 deb_q, prev_q, armed_q;
  logic                       mode_q;
  logic [4:0]                 stack_q, stack_d;
  logic [2:0]                 count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic [TICK_W-1:0]          press_cnt_q, press_cnt_d;
  logic [TICK_W-1:0]          gap_q, gap_d;
  logic [HIST_DEPTH-1:0][5:0] hist_q, hist_d;
  logic [5:0]                 last_q, last_d;
  logic                       valid_q;

  logic [3:0] press;
  logic       rel0, mode_chg, confirm, push, sym, gap_run;
  logic [5:0] code;

  function automatic logic [5:0] decode(input logic [4:0] s, input logic [2:0] n,
                                        input logic ovf);
    logic [5:0] c;
    c = 6'd63;
    if (!ovf) begin
      case (n)
        3'd1: c = s[0] ? 6'd19 : 6'd4;
        3'd2: case (s[1:0])
          2'b00: c = 6'd8;  2'b01: c = 6'd0;
          2'b10: c = 6'd13; default: c = 6'd12;
        endcase
        3'd3: case (s[2:0])
          3'b000: c = 6'd18; 3'b001: c = 6'd20; 3'b010: c = 6'd17; 3'b011: c = 6'd22;
          3'b100: c = 6'd3;  3'b101: c = 6'd10; 3'b110: c = 6'd6;  default: c = 6'd14;
        endcase
        3'd4: case (s[3:0])
          4'b0000: c = 6'd7;  4'b0001: c = 6'd21; 4'b0010: c = 6'd5;
          4'b0100: c = 6'd11; 4'b0110: c = 6'd15; 4'b0111: c = 6'd9;
          4'b1000: c = 6'd1;  4'b1001: c = 6'd23; 4'b1010: c = 6'd2;
          4'b1011: c = 6'd24; 4'b1100: c = 6'd25; 4'b1101: c = 6'd16;
          default: c = 6'd63;
        endcase
        3'd5: case (s)
          5'b11111: c = 6'd26; 5'b01111: c = 6'd27; 5'b00111: c = 6'd28;
          5'b00011: c = 6'd29; 5'b00001: c = 6'd30; 5'b00000: c = 6'd31;
          5'b10000: c = 6'd32; 5'b11000: c = 6'd33; 5'b11100: c = 6'd34;
          5'b11110: c = 6'd35;
          default:  c = 6'd63;
        endcase
        default: c = 6'd63;
      endcase
    end
    return c;
  endfunction

  // A key only produces edges once it has been seen released after reset,
  // so a key held through reset stays silent until re-pressed.
  assign press    = armed_q & ~deb_q & prev_q;
  assign rel0     = armed_q[0] & deb_q[0] & ~prev_q[0];
  assign mode_chg = wMode != mode_q;
  assign code     = decode(stack_q, count_q, ovf_q);
  assign gap_run  = deb_q[0] && (count_q != 3'd0 || ovf_q);

  always_comb begin
    stack_d     = stack_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    press_cnt_d = press_cnt_q;
    gap_d       = gap_q;
    confirm     = 1'b0;
    push        = 1'b0;
    sym         = 1'b0;
    if (mode_chg) begin
      stack_d     = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
      press_cnt_d = '0;
      gap_d       = '0;
    end else if (!wMode) begin
      if (press[2]) begin
        stack_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end else if (press[3]) begin
        confirm = count_q != 3'd0;
      end else if (press[0]) begin
        push = 1'b1;
      end else if (press[1]) begin
        push = 1'b1;
        sym  = 1'b1;
      end
    end else begin
      if (!deb_q[0]) begin
        gap_d = '0;
        if (wTick && press_cnt_q != '1) press_cnt_d = press_cnt_q + TICK_W'(1);
      end else if (gap_run && wTick) begin
        gap_d = gap_q + TICK_W'(1);
      end
      if (rel0) press_cnt_d = '0;
      if (press[2]) begin
        stack_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        gap_d   = '0;
      end else if (gap_run && wTick && gap_q == GAP_END) begin
        confirm = 1'b1;
        gap_d   = '0;
      end else if (rel0) begin
        push = 1'b1;
        sym  = press_cnt_q >= DASH_T;
      end
    end
    if (confirm) begin
      stack_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (push) begin
      if (count_q == 3'd5) begin
        ovf_d = 1'b1;
      end else begin
        stack_d = {stack_q[3:0], sym};
        count_d = count_q + 3'd1;
      end
    end
  end

  always_comb begin
    hist_d = hist_q;
    last_d = last_q;
    if (confirm) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = code;
      last_d    = code;
    end
    if (wSW) hist_d = '1;
  end

  always_ff @(posedge wiCLK or negedge wrst) begin
    if (!wrst) begin
      sh_q        <= '1;
      deb_q       <= '1;
      prev_q      <= '1;
      armed_q     <= '0;
      mode_q      <= 1'b0;
      stack_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      press_cnt_q <= '0;
      gap_q       <= '0;
      hist_q      <= '1;
      last_q      <= 6'd63;
      valid_q     <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        sh_q[k] <= {sh_q[k][DEBOUNCE-2:0], wKEY[k]};
        if (&sh_q[k])       deb_q[k] <= 1'b1;
        else if (~|sh_q[k]) deb_q[k] <= 1'b0;
        if (deb_q[k] && wKEY[k]) armed_q[k] <= 1'b1;
      end
      prev_q      <= deb_q;
      mode_q      <= wMode;
      stack_q     <= stack_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      press_cnt_q <= press_cnt_d;
      gap_q       <= gap_d;
      hist_q      <= hist_d;
      last_q      <= last_d;
      valid_q     <= confirm;
    end
  end

  assign wHist  = hist_q;
  assign wLast  = last_q;
  assign wValid = valid_q;
  assign wStack = stack_q;
  assign wCount = count_q;
  assign wOvf   = ovf_q;

endmodule

// File: tb/tb_morse_rx_param.sv
// Directed bench for morse_rx_param: button mode, overflow, clear, debounce,
// straight-key timing mode, history hold and mid-operation reset.
module tb_morse_rx_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key;
  logic        mode, tick, sw;
  logic [23:0] hist;
  logic [5:0]  last;
  logic        valid;
  logic [4:0]  stack;
  logic [2:0]  count;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;
  int vbase;

  morse_rx_param dut (
    .wiCLK (clk),
    .wrst  (rst_n),
    .wKEY  (key),
    .wMode (mode),
    .wTick (tick),
    .wSW   (sw),
    .wHist (hist),
    .wLast (last),
    .wValid(valid),
    .wStack(stack),
    .wCount(count),
    .wOvf  (ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcount++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks (called aligned to a falling edge)
  task automatic tap(input int k);
    key[k] = 1'b0;
    repeat (8) @(negedge clk);
    key[k] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_ticks(input int n);
    key[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) pulse_tick();
    key[0] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'hF;
    mode  = 1'b0;
    tick  = 1'b0;
    sw    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_hist",  hist,  24'hFFFFFF);
    check("rst_last",  last,  6'd63);
    check("rst_valid", valid, 1'b0);
    check("rst_stack", stack, 5'd0);
    check("rst_count", count, 3'd0);
    check("rst_ovf",   ovf,   1'b0);

    // dot with exact debounce latency, then dash, then confirm -> A
    key[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("dot_early", count, 3'd0);
    @(negedge clk);
    check("dot_land", count, 3'd1);
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
    repeat (8) @(negedge clk);
    check("dot_stack", stack, 5'd0);
    tap(1);
    check("dash_count", count, 3'd2);
    check("dash_stack", stack, 5'b00001);
    vbase  = vcount;
    key[3] = 1'b0;
    repeat (5) @(negedge clk);
    check("conf_early", valid, 1'b0);
    @(negedge clk);
    check("conf_valid", valid, 1'b1);
    check("conf_last",  last,  6'd0);
    check("conf_hist",  hist,  24'hFFFFC0);
    check("conf_count", count, 3'd0);
    @(negedge clk);
    check("conf_pulse_end", valid, 1'b0);
    key[3] = 1'b1;
    repeat (8) @(negedge clk);
    check("conf_vcount", vcount, vbase + 1);

    // five dots -> 5, five dashes -> 0
    for (int i = 0; i < 5; i++) tap(0);
    tap(3);
    check("five_dots", last, 6'd31);
    for (int i = 0; i < 5; i++) tap(1);
    check("five_dash_stack", stack, 5'b11111);
    tap(3);
    check("five_dash", last, 6'd26);
    check("hist_pair", hist[11:0], {6'd31, 6'd26});
    check("hist_full", hist, {6'd63, 6'd0, 6'd31, 6'd26});

    // overflow
    for (int i = 0; i < 6; i++) tap(0);
    check("ovf_count", count, 3'd5);
    check("ovf_flag",  ovf,   1'b1);
    check("ovf_stack", stack, 5'd0);
    vbase = vcount;
    tap(3);
    check("ovf_last",  last, 6'd63);
    check("ovf_clear", ovf,  1'b0);
    check("ovf_hist0", hist[5:0], 6'd63);
    tap(3);
    check("empty_conf", vcount, vbase + 1);

    // clear beats confirm; short glitch ignored
    tap(0);
    tap(1);
    vbase = vcount;
    key   = 4'b0011;
    repeat (8) @(negedge clk);
    key   = 4'hF;
    repeat (8) @(negedge clk);
    check("clr_count", count, 3'd0);
    check("clr_stack", stack, 5'd0);
    check("clr_novalid", vcount, vbase);
    key[0] = 1'b0;
    repeat (3) @(negedge clk);
    key[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch", count, 3'd0);

    // timing mode: 1 tick = dot, 4 ticks = dash, 7 idle ticks confirm A
    mode = 1'b1;
    repeat (3) @(negedge clk);
    press_ticks(1);
    check("tm_dot_count", count, 3'd1);
    check("tm_dot_stack", stack, 5'd0);
    press_ticks(4);
    check("tm_dash_count", count, 3'd2);
    check("tm_dash_stack", stack, 5'b00001);
    vbase = vcount;
    for (int i = 0; i < 6; i++) pulse_tick();
    check("gap6_novalid", vcount, vbase);
    check("gap6_count",   count,  3'd2);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("gap7_valid", valid, 1'b1);
    check("gap7_last",  last,  6'd0);
    check("gap7_count", count, 3'd0);
    check("gap7_hist",  hist,  {6'd31, 6'd26, 6'd63, 6'd0});
    @(negedge clk);
    check("gap7_pulse_end", valid, 1'b0);
    vbase = vcount;
    for (int i = 0; i < 10; i++) pulse_tick();
    check("idle_novalid", vcount, vbase);
    // boundary: exactly DASH_TICKS is a dash, one less is a dot; clear still works
    press_ticks(3);
    check("tm_3tick", stack, 5'b00001);
    press_ticks(2);
    check("tm_2tick", stack, 5'b00010);
    check("tm_2count", count, 3'd2);
    tap(2);
    check("tm_clear", count, 3'd0);

    // history hold
    mode = 1'b0;
    repeat (3) @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    check("sw_hist", hist, 24'hFFFFFF);
    tap(0);
    tap(3);
    check("sw_last", last, 6'd4);
    check("sw_hist_held", hist, 24'hFFFFFF);
    sw = 1'b0;
    @(negedge clk);

    // reset mid-symbol with a key held through it
    tap(0);
    tap(0);
    check("pre_rst_count", count, 3'd2);
    key[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hist",  hist,  24'hFFFFFF);
    check("mid_rst_last",  last,  6'd63);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_stack", stack, 5'd0);
    check("mid_rst_count", count, 3'd0);
    check("mid_rst_ovf",   ovf,   1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("held_key", count, 3'd0);
    key[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("held_release", count, 3'd0);
    tap(0);
    check("after_rst_dot", count, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
